// File: rtl/fib_sched_pkg.sv
// +--------------------------------------------------------------------+
// | fib_sched_pkg : shared state encoding and width helpers for the    |
// |                 Fibonacci engine scheduler.                        |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package fib_sched_pkg;

  typedef logic [1:0] sched_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fib_engine_scheduler_rr_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, first request at or   |
// |              after the pointer, wrapping.                          |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
  import fib_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]              i_req,
  input  logic [idx_width(N)-1:0]   i_ptr,
  output logic [N-1:0]              o_grant,
  output logic [idx_width(N)-1:0]   o_idx,
  output logic                      o_any
);

  localparam int IW = idx_width(N);

  logic [IW-1:0] w_pos [N];

  // w_pos[k] is the requester k places after the pointer, modulo N
  for (genvar k = 0; k < N; k++) begin : g_pos
    logic [IW:0] w_sum;
    assign w_sum    = {1'b0, i_ptr} + (IW+1)'(k);
    assign w_pos[k] = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
  end

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!o_any && i_req[w_pos[k]]) begin
        o_any            = 1'b1;
        o_idx            = w_pos[k];
        o_grant[w_pos[k]] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fib_engine_scheduler.sv
// +--------------------------------------------------------------------+
// | fib_engine_scheduler : round-robin sharing of one fibonacci engine |
// |                        among NUM_REQ requesters, with timeout.     |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module fib_engine_scheduler
  import fib_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_n,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [WIDTH-1:0]           rsp_fib,
  output logic                       rsp_err,
  output logic                       eng_start,
  output logic [WIDTH-1:0]           eng_n,
  input  logic                       eng_done,
  input  logic [WIDTH-1:0]           eng_fib,
  output logic                       busy
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = cnt_width(TIMEOUT);

  sched_state_t         r_state;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_g;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [CW-1:0]        r_cnt;
  logic [NUM_REQ-1:0]   r_req_ready;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [WIDTH-1:0]     r_rsp_fib;
  logic                 r_rsp_err;
  logic                 r_eng_start;
  logic [WIDTH-1:0]     r_eng_n;
  logic                 r_busy;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IW-1:0]        w_idx;
  logic                 w_any;
  logic [WIDTH-1:0]     w_sel_n;
  logic                 w_rsp_hs;
  logic [IW-1:0]        w_ptr_next;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_sel_n    = req_n[w_idx*WIDTH +: WIDTH];
  // r_rsp_valid is one-hot on the granted lane, so other lanes' ready is masked
  assign w_rsp_hs   = |(rsp_ready & r_rsp_valid);
  assign w_ptr_next = (r_g == IW'(NUM_REQ - 1)) ? '0 : r_g + IW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_g         <= '0;
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_fib   <= '0;
      r_rsp_err   <= 1'b0;
      r_eng_start <= 1'b0;
      r_eng_n     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_req_ready <= '0;
      r_eng_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_g         <= w_idx;
            r_gnt       <= w_grant;
            r_req_ready <= w_grant;
            r_eng_start <= 1'b1;
            r_eng_n     <= w_sel_n;
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          // done is checked first so it wins over a coincident timeout
          if (eng_done) begin
            r_rsp_fib   <= eng_fib;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= r_gnt;
            r_state     <= ST_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_rsp_fib   <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= r_gnt;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= '0;
            r_ptr       <= w_ptr_next;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_fib   = r_rsp_fib;
  assign rsp_err   = r_rsp_err;
  assign eng_start = r_eng_start;
  assign eng_n     = r_eng_n;
  assign busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_fib_engine_scheduler.sv
// +--------------------------------------------------------------------+
// | tb_fib_engine_scheduler : directed vector bench for the scheduler. |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fib_engine_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_n = '0;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready = '0;
  logic [7:0]  rsp_fib;
  logic        rsp_err;
  logic        eng_start;
  logic [7:0]  eng_n;
  logic        eng_done = 1'b0;
  logic [7:0]  eng_fib = '0;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fib_engine_scheduler #(.NUM_REQ(4), .WIDTH(8), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_n     (req_n),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_fib   (rsp_fib),
    .rsp_err   (rsp_err),
    .eng_start (eng_start),
    .eng_n     (eng_n),
    .eng_done  (eng_done),
    .eng_fib   (eng_fib),
    .busy      (busy)
  );

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] nvec;
    int          lat;
    int          exp_g;
    logic [7:0]  exp_fib;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // behavioural engine result, 8-bit wrap
  function automatic logic [7:0] fibf(input logic [7:0] n);
    logic [7:0] a, b, t;
    a = 8'd0;
    b = 8'd1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic logic [31:0] outs_vec();
    return {req_ready, rsp_valid, rsp_fib, rsp_err, eng_start, eng_n, busy};
  endfunction

  // lat < 0: the engine never answers
  task automatic run_txn(input logic [3:0] mask, input logic [31:0] nvec, input int lat,
                         input int hold, input bit spur,
                         output int g, output logic [7:0] fib, output logic err, output int cyc);
    int         waitc;
    logic [7:0] n;
    bit         bad;
    g = 0; fib = '0; err = 1'b0; cyc = 0;
    req_valid = mask;
    req_n     = nvec;
    waitc     = 0;
    while (req_ready == 4'd0 && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    if (req_ready == 4'd0) begin
      chk("grant_wait_expired", 32'd0, 32'd1);
      req_valid = '0;
      return;
    end
    for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
    n = nvec[g*8 +: 8];
    chk("req_ready_onehot", $countones(req_ready), 1);
    chk("eng_start_pulse", {31'd0, eng_start}, 1);
    chk("eng_n", {24'd0, eng_n}, {24'd0, n});
    chk("busy_in_issue", {31'd0, busy}, 1);
    @(posedge clk); #1; cyc = 1;
    req_valid[g] = 1'b0;
    chk("eng_start_single", {31'd0, eng_start}, 0);
    if (lat >= 0) begin
      repeat (lat) begin @(posedge clk); #1; cyc++; end
      eng_done = 1'b1;
      eng_fib  = fibf(n);
      @(posedge clk); #1; cyc++;
      eng_done = 1'b0;
      eng_fib  = 8'h00;
    end
    while (rsp_valid == 4'd0 && cyc < 400) begin
      @(posedge clk); #1; cyc++;
    end
    if (rsp_valid == 4'd0) begin
      chk("rsp_wait_expired", 32'd0, 32'd1);
      return;
    end
    chk("rsp_lane", {28'd0, rsp_valid}, 32'(1 << g));
    fib = rsp_fib;
    err = rsp_err;
    bad = 1'b0;
    rsp_ready = ~(4'(1 << g));
    for (int i = 0; i < hold; i++) begin
      if (rsp_valid != 4'(1 << g) || rsp_fib != fib || rsp_err != err || eng_start) bad = 1'b1;
      eng_done = spur && (i == 0);
      eng_fib  = 8'hAA;
      @(posedge clk); #1;
    end
    eng_done = 1'b0;
    chk("rsp_hold_stable", {31'd0, bad}, 0);
    rsp_ready = 4'(1 << g);
    @(posedge clk); #1;
    rsp_ready = '0;
    chk("rsp_valid_drop", {28'd0, rsp_valid}, 0);
    chk("busy_after_rsp", {31'd0, busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         g, cyc;
    logic [7:0] fib;
    logic       err;
    bit         bad;

    tbl[0] = '{4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, 3, 0, 8'd1};
    tbl[1] = '{4'b1110, {8'd4, 8'd3, 8'd2, 8'd1}, 3, 1, 8'd1};
    tbl[2] = '{4'b1100, {8'd4, 8'd3, 8'd2, 8'd1}, 3, 2, 8'd2};
    tbl[3] = '{4'b1000, {8'd4, 8'd3, 8'd2, 8'd1}, 3, 3, 8'd3};
    tbl[4] = '{4'b1001, {8'd9, 8'd0, 8'd0, 8'd5}, 2, 0, 8'd5};
    tbl[5] = '{4'b1000, {8'd9, 8'd0, 8'd0, 8'd5}, 5, 3, 8'd34};

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs_vec(), 0);
    rst = 1'b1;

    // round-robin order from pointer 0, then lanes 0 and 3 only
    foreach (tbl[i]) begin
      run_txn(tbl[i].mask, tbl[i].nvec, tbl[i].lat, 0, 1'b0, g, fib, err, cyc);
      chk($sformatf("tbl%0d_grant", i), g, tbl[i].exp_g);
      chk($sformatf("tbl%0d_fib", i), {24'd0, fib}, {24'd0, tbl[i].exp_fib});
      chk($sformatf("tbl%0d_err", i), {31'd0, err}, 0);
    end

    // single request, engine latency 12
    run_txn(4'b0100, {8'd0, 8'd10, 8'd0, 8'd0}, 12, 0, 1'b0, g, fib, err, cyc);
    chk("single_grant", g, 2);
    chk("single_fib", {24'd0, fib}, 55);
    chk("single_err", {31'd0, err}, 0);
    chk("single_latency", cyc, 14);

    // backpressure: response held 20 cycles
    run_txn(4'b0010, {8'd0, 8'd0, 8'd7, 8'd0}, 3, 20, 1'b0, g, fib, err, cyc);
    chk("bp_grant", g, 1);
    chk("bp_fib", {24'd0, fib}, 13);

    // engine never answers
    run_txn(4'b0001, {8'd0, 8'd0, 8'd0, 8'd6}, -1, 0, 1'b0, g, fib, err, cyc);
    chk("to_grant", g, 0);
    chk("to_err", {31'd0, err}, 1);
    chk("to_fib", {24'd0, fib}, 0);
    chk("to_latency", cyc, 16);

    // done lands in the final WAIT cycle
    run_txn(4'b1000, {8'd12, 8'd0, 8'd0, 8'd0}, 14, 0, 1'b0, g, fib, err, cyc);
    chk("edge_grant", g, 3);
    chk("edge_err", {31'd0, err}, 0);
    chk("edge_fib", {24'd0, fib}, 144);
    chk("edge_latency", cyc, 16);

    // spurious done in IDLE
    eng_done = 1'b1;
    eng_fib  = 8'hAA;
    @(posedge clk); #1;
    eng_done = 1'b0;
    @(posedge clk); #1;
    chk("spur_idle_busy", {31'd0, busy}, 0);
    chk("spur_idle_fib", {24'd0, rsp_fib}, 144);
    chk("spur_idle_rsp", {28'd0, rsp_valid}, 0);

    // pointer still 0 so lane 1 wins; spurious done during RESP
    run_txn(4'b0110, {8'd0, 8'd9, 8'd8, 8'd0}, 4, 3, 1'b1, g, fib, err, cyc);
    chk("spur_resp_grant", g, 1);
    chk("spur_resp_fib", {24'd0, fib}, 21);
    run_txn(4'b1111, {8'd1, 8'd2, 8'd3, 8'd4}, 2, 0, 1'b0, g, fib, err, cyc);
    chk("ptr_after_spur", g, 2);

    // reset while in WAIT
    req_valid = 4'b0100;
    req_n     = {8'd0, 8'd6, 8'd0, 8'd0};
    bad       = 1'b1;
    for (int i = 0; i < 20 && bad; i++) begin
      @(posedge clk); #1;
      if (req_ready != 4'd0) bad = 1'b0;
    end
    chk("mid_reset_grant", {31'd0, bad}, 0);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("mid_reset_busy_before", {31'd0, busy}, 1);
    rst = 1'b0;
    #1;
    chk("mid_reset_outputs", outs_vec(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp_valid != 4'd0 || eng_start || busy) bad = 1'b1;
    end
    chk("mid_reset_quiet", {31'd0, bad}, 0);
    run_txn(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, 1, 0, 1'b0, g, fib, err, cyc);
    chk("post_reset_grant", g, 0);
    chk("post_reset_fib", {24'd0, fib}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fib_engine_scheduler.md
Name: fib_engine_scheduler

Overview:
- Shares one fibonacci_gen engine among NUM_REQ requesters.
- Each requester presents n with a valid/ready handshake. The scheduler grants round-robin, issues a one-cycle start to the engine and waits for engine done, with a timeout.
- Returns fib to the granted requester over a valid/ready response channel.
- Sits between the client ports and the single engine instance in the Fibonacci subsystem.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, width of n and fib.
- TIMEOUT, 255, maximum cycles in WAIT before aborting; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester request accept; one-hot or zero.
- req_n  in  NUM_REQ*WIDTH  packed n values; slice i = bits [i*WIDTH +: WIDTH].
- rsp_valid  out  NUM_REQ  per-requester response valid; one-hot or zero.
- rsp_ready  in  NUM_REQ  per-requester response accept.
- rsp_fib  out  WIDTH  result, shared by all requesters; qualified by rsp_valid.
- rsp_err  out  1  response is a timeout abort; qualified by rsp_valid.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_n  out  WIDTH  operand to the engine; held stable from start until done.
- eng_done  in  1  engine completion pulse.
- eng_fib  in  WIDTH  engine result; valid when eng_done=1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE, rr_ptr = 0, counter = 0.
  - req_ready = 0, rsp_valid = 0, rsp_fib = 0, rsp_err = 0, eng_start = 0, eng_n = 0, busy = 0.
- All outputs are registered. Deasserting reset takes effect at the next clk edge.

State machine:
- IDLE: if any req_valid is high, rr_arbiter picks the first requester at or after rr_ptr (wrapping). The scheduler latches grant index g and n = req_n[g], pulses req_ready[g] for one cycle (the handshake completes that cycle), and moves to ISSUE. If no request is pending, it stays in IDLE.
- ISSUE: eng_start = 1 for exactly one cycle with eng_n = latched n; counter cleared. Next state WAIT.
- WAIT: counter increments each cycle.
  - eng_done = 1: capture eng_fib into rsp_fib, rsp_err = 0, go to RESP.
  - counter reaches TIMEOUT without eng_done: rsp_fib = 0, rsp_err = 1, go to RESP.
  - eng_done on the same cycle the counter reaches TIMEOUT: eng_done wins and rsp_err = 0.
- RESP: rsp_valid[g] = 1. rsp_fib and rsp_err are held stable until rsp_ready[g] = 1. On that handshake: rsp_valid drops, rr_ptr = (g+1) mod NUM_REQ, next state IDLE.

Timing and arbitration:
- Best-case latency from request acceptance to rsp_valid: 2 + engine latency cycles.
- A new grant is issued no earlier than the cycle after the response handshake.
- Only one request is ever in flight.
- rr_ptr advances only on a completed response, including timeout responses.
- A requester that drops req_valid before being granted is simply skipped; no error.
- eng_done while in IDLE, ISSUE or RESP is ignored.
- rsp_ready on non-granted lanes is ignored.
- The scheduler does not compute or check fib values, and does not check for n overflow. Width wrap of the result is the engine's behaviour.
- A reset during WAIT abandons the in-flight request: no response is issued and the engine is not re-started.

Decomposition:
- Shared package fib_sched_pkg holds:
  - the state enum {IDLE, ISSUE, WAIT, RESP} (2-bit);
  - localparam helpers for grant-index width ($clog2(NUM_REQ)) and counter width.
- Sub-module rr_arbiter (parameter N): combinational round-robin priority pick.
  - Inputs: request vector and rr_ptr.
  - Outputs: one-hot grant, grant index, any_req.

Test Plan:
- Single request: requester 2 sends n=10; the engine model returns done with fib=55 after 12 cycles. Expect eng_start once with eng_n=10, then rsp_valid[2]=1 with rsp_fib=55 and rsp_err=0, 14 cycles after acceptance.
- Round-robin fairness: all 4 requesters hold valid with n=1,2,3,4. Expect grant order 0,1,2,3 and responses 1,1,2,3. Then only requester 0 and 3 request with rr_ptr=0: expect 0, then 3.
- Backpressure: rsp_ready[1] is held low for 20 cycles. Expect rsp_valid[1] and rsp_fib=13 (n=7) stable for the whole period, and no new eng_start until the handshake completes.
- Timeout: TIMEOUT=15 and the engine never asserts done. Expect rsp_valid with rsp_err=1 and rsp_fib=0 after 15 WAIT cycles. Then eng_done and timeout on the same cycle: expect rsp_err=0.
- Reset mid-operation: assert rst=0 while in WAIT. All outputs go to 0 asynchronously within the same cycle, with no rsp_valid afterwards. After release, the next request is granted starting from requester 0.
- Spurious done: pulse eng_done while in IDLE and while in RESP. State, rsp_fib and rr_ptr are unchanged.
